// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shift unit: op codes, amount sources, FSM states.
// Optional rotate support is enabled with the SHIFT_ROTATE_EN macro in shift_unit_seq.
package shift_pkg;

    localparam logic [2:0] SH_NOP = 3'b000;
    localparam logic [2:0] SH_SLL = 3'b001;
    localparam logic [2:0] SH_SRL = 3'b010;
    localparam logic [2:0] SH_SRA = 3'b011;
    localparam logic [2:0] SH_ROR = 3'b100;

    localparam logic [1:0] SEL_SHAMT = 2'b00;
    localparam logic [1:0] SEL_REGB  = 2'b01;
    localparam logic [1:0] SEL_MEM   = 2'b10;
    localparam logic [1:0] SEL_K16   = 2'b11;

    localparam int K16_AMT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shamt_select.sv
// Combinational amount-source mux: picks shamt, reg B, memory data or the LUI constant
// and keeps only the low AMT_W bits as the effective shift amount.
module shamt_select
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic [1:0]        amt_sel,
    input  logic [4:0]        shamt_in,
    input  logic [DATA_W-1:0] regb_in,
    input  logic [DATA_W-1:0] mem_in,
    output logic [AMT_W-1:0]  amt
);

    logic [DATA_W-1:0] src;
    logic              unused_src_hi;

    always_comb begin
        src = '0;
        case (amt_sel)
            SEL_SHAMT: src = DATA_W'(shamt_in);
            SEL_REGB:  src = regb_in;
            SEL_MEM:   src = mem_in;
            SEL_K16:   src = DATA_W'(K16_AMT);
            default:   src = '0;
        endcase
    end

    // Upper source bits never affect the amount.
    assign unused_src_hi = ^src[DATA_W-1:AMT_W];
    assign amt           = src[AMT_W-1:0];

endmodule

// File: rtl/shift_unit_seq.sv
// Multicycle shifter: latches operands on start, shifts up to STEP bits per cycle, pulses done.
// Define SHIFT_ROTATE_EN to add SH_ROR; otherwise op 100 is illegal like 101-111.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [1:0]        amt_sel,
    input  logic [4:0]        shamt_in,
    input  logic [DATA_W-1:0] regb_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              op_err,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        dbg_state
);

    localparam int AMT_W = $clog2(DATA_W);
    localparam logic [AMT_W:0] STEP_C = (AMT_W+1)'(STEP);
`ifdef SHIFT_ROTATE_EN
    localparam logic [AMT_W:0] DW_C = (AMT_W+1)'(DATA_W);
`endif

    // Handshake: start is sampled only in IDLE; busy is high during SHIFT; done and
    // op_err pulse for exactly one cycle, and result stays valid until the next accepted start.

    state_e            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;

    logic [AMT_W-1:0]  amt;
    logic [AMT_W:0]    step_amt;
    logic [DATA_W-1:0] shifted;
    logic              op_legal;

    shamt_select #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shamt_select (
        .amt_sel  (amt_sel),
        .shamt_in (shamt_in),
        .regb_in  (regb_in),
        .mem_in   (mem_in),
        .amt      (amt)
    );

    always_comb begin
`ifdef SHIFT_ROTATE_EN
        op_legal = (op <= SH_ROR);
`else
        op_legal = (op <= SH_SRA);
`endif
    end

    always_comb begin
        step_amt = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
        shifted  = work_q;
        case (op_q)
            SH_SLL:  shifted = work_q << step_amt;
            SH_SRL:  shifted = work_q >> step_amt;
            SH_SRA:  shifted = $signed(work_q) >>> step_amt;
`ifdef SHIFT_ROTATE_EN
            SH_ROR:  shifted = (work_q >> step_amt) | (work_q << (DW_C - step_amt));
`endif
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        rem_d    = rem_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = data_in;
                    op_d   = op_legal ? op : SH_NOP;
                    err_d  = !op_legal;
                    rem_d  = amt;
                    if (amt == '0) begin
                        state_d  = ST_DONE;
                        result_d = data_in;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_amt[AMT_W-1:0];
                // Leave on the step that drains the count so done lands in cycle k+1.
                if ({1'b0, rem_q} <= STEP_C) begin
                    state_d  = ST_DONE;
                    result_d = shifted;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= SH_NOP;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign op_err    = done & err_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (DATA_W=32, STEP=4) using an expected-result queue.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  amt_sel;
    logic [4:0]  shamt_in;
    logic [31:0] regb_in, mem_in, data_in;
    logic        busy, done, op_err;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sel;
        logic [4:0]  shamt;
        logic [31:0] regb;
        logic [31:0] mem;
        logic [31:0] data;
    } vec_t;

    shift_unit_seq #(.DATA_W(32), .STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .amt_sel   (amt_sel),
        .shamt_in  (shamt_in),
        .regb_in   (regb_in),
        .mem_in    (mem_in),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .op_err    (op_err),
        .result    (result),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic bit legal_op(input logic [2:0] o);
`ifdef SHIFT_ROTATE_EN
        return o <= 3'd4;
`else
        return o <= 3'd3;
`endif
    endfunction

    function automatic logic [4:0] eff_amt(input logic [1:0] sel, input logic [4:0] sh,
                                           input logic [31:0] rb, input logic [31:0] mm);
        case (sel)
            2'b00:   return sh;
            2'b01:   return rb[4:0];
            2'b10:   return mm[4:0];
            default: return 5'd16;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] a,
                                          input logic [31:0] d);
        logic [63:0] dd;
        case (o)
            3'd1:    return d << a;
            3'd2:    return d >> a;
            3'd3:    return $signed(d) >>> a;
            3'd4: begin
                dd = {d, d} >> a;
                return dd[31:0];
            end
            default: return d;
        endcase
    endfunction

    // Pushes the expectation, then holds start for exactly one edge.
    task automatic issue(input vec_t v);
        logic [4:0] a;
        a = eff_amt(v.sel, v.shamt, v.regb, v.mem);
        if (legal_op(v.op)) begin
            exp_q.push_back(model(v.op, a, v.data));
            exp_err_q.push_back(1'b0);
            exp_lat_q.push_back((int'(a) + 3) / 4 + 1);
        end else begin
            exp_q.push_back(v.data);
            exp_err_q.push_back(1'b1);
            exp_lat_q.push_back(-1);
        end
        @(posedge clk);
        #1;
        op = v.op; amt_sel = v.sel; shamt_in = v.shamt;
        regb_in = v.regb; mem_in = v.mem; data_in = v.data;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = $urandom_range(7, 0);
        data_in = $urandom();
    endtask

    // Samples mid-cycle until done; lat is the cycle index of done (1 = first cycle after start edge).
    task automatic collect(output logic [31:0] res, output logic err, output int lat,
                           output int bcnt);
        bit got;
        got = 0; lat = 0; bcnt = 0; res = '0; err = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1; lat = c; res = result; err = op_err;
            end else begin
                if (busy) bcnt++;
                @(posedge clk);
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done within 100 cycles, required done pulse");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; amt_sel = '0; shamt_in = '0;
        regb_in = '0; mem_in = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL reset_op_err got %b exp 0", op_err); end
        n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
        n_cmp++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", dbg_state); end
    endtask

    task automatic test_directed();
        vec_t        tbl[7];
        logic [31:0] res, e_res;
        logic        err, e_err;
        int          lat, bcnt, e_lat;
        tbl[0] = '{3'b001, 2'b00, 5'd31, 32'h0,        32'h0,  32'h00000001};
        tbl[1] = '{3'b011, 2'b01, 5'd0,  32'hFFFFFFE4, 32'h0,  32'h80000000};
        tbl[2] = '{3'b010, 2'b11, 5'd0,  32'h0,        32'h0,  32'hABCD1234};
        tbl[3] = '{3'b010, 2'b10, 5'd0,  32'h0,        32'h10, 32'hABCD1234};
        tbl[4] = '{3'b001, 2'b00, 5'd0,  32'h0,        32'h0,  32'h12345678};
        tbl[5] = '{3'b111, 2'b00, 5'd0,  32'h0,        32'h0,  32'h12345678};
        tbl[6] = '{3'b100, 2'b00, 5'd4,  32'h0,        32'h0,  32'h0000000F};
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i]);
            collect(res, err, lat, bcnt);
            e_res = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
            n_cmp++;
            if (res !== e_res) begin n_fail++; $display("FAIL dir%0d_result got %h exp %h", i, res, e_res); end
            n_cmp++;
            if (err !== e_err) begin n_fail++; $display("FAIL dir%0d_op_err got %b exp %b", i, err, e_err); end
            if (e_lat >= 0) begin
                n_cmp++;
                if (lat !== e_lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, e_lat); end
                n_cmp++;
                if (bcnt !== e_lat - 1) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, bcnt, e_lat - 1); end
            end
        end
        // Spec anchors independent of the model.
        n_cmp++;
        if (model(3'b001, 5'd31, 32'h1) !== 32'h80000000 || model(3'b011, 5'd4, 32'h80000000) !== 32'hF8000000)
            begin n_fail++; $display("FAIL model_anchor got mismatch exp spec values"); end
    endtask

    task automatic test_ignore_start();
        vec_t        v, w;
        logic [31:0] res, e_res;
        logic        err, e_err;
        int          lat, bcnt, e_lat;
        v = '{3'b001, 2'b00, 5'd31, 32'h0, 32'h0, 32'h00000001};
        w = '{3'b010, 2'b00, 5'd1,  32'h0, 32'h0, 32'hDEADBEEF};
        issue(v);
        @(posedge clk); #1;
        op = w.op; shamt_in = w.shamt; data_in = w.data; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        collect(res, err, lat, bcnt);
        e_res = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        n_cmp++;
        if (res !== e_res) begin n_fail++; $display("FAIL ignore_start_result got %h exp %h", res, e_res); end
        n_cmp++;
        if (lat !== e_lat - 2) begin n_fail++; $display("FAIL ignore_start_latency got %0d exp %0d", lat, e_lat - 2); end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ignore_start_idle got busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_reset_mid();
        vec_t        v;
        logic [31:0] res, e_res;
        logic        err, e_err;
        int          lat, bcnt, e_lat;
        v = '{3'b001, 2'b00, 5'd20, 32'h0, 32'h0, 32'h00000003};
        issue(v);
        void'(exp_q.pop_back()); void'(exp_err_q.pop_back()); void'(exp_lat_q.pop_back());
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
            begin n_fail++; $display("FAIL reset_mid got busy=%b done=%b result=%h exp 0 0 0", busy, done, result); end
        @(posedge clk); #1 reset = 1'b0;
        v = '{3'b010, 2'b00, 5'd5, 32'h0, 32'h0, 32'hF0F0F0F0};
        issue(v);
        collect(res, err, lat, bcnt);
        e_res = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        n_cmp++;
        if (res !== e_res || lat !== e_lat) begin n_fail++; $display("FAIL after_reset got %h/%0d exp %h/%0d", res, lat, e_res, e_lat); end
    endtask

    task automatic test_back_to_back();
        vec_t        v;
        logic [31:0] res, e_res;
        logic        err, e_err;
        int          lat, bcnt, e_lat;
        for (int i = 0; i < 24; i++) begin
            v.op    = 3'($urandom_range(3, 0));
            v.sel   = 2'($urandom_range(3, 0));
            v.shamt = 5'($urandom_range(31, 0));
            v.regb  = $urandom();
            v.mem   = $urandom();
            v.data  = $urandom();
            if (i % 4 == 0) v.data[31] = 1'b1;
            issue(v);
            collect(res, err, lat, bcnt);
            e_res = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
            n_cmp++;
            if (res !== e_res || err !== e_err)
                begin n_fail++; $display("FAIL b2b%0d_result got %h/%b exp %h/%b", i, res, err, e_res, e_err); end
            n_cmp++;
            if (lat !== e_lat) begin n_fail++; $display("FAIL b2b%0d_latency got %0d exp %0d", i, lat, e_lat); end
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b exp 0", done); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
